// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle A + B + Cin adder, CHUNK bits per clock
//
// Computes (A + B + Cin) over WIDTH bits, CHUNK bits per clock, with the carry
// held in a register between chunks. Valid/ready handshakes on both sides.
// Optional macro CHUNKED_SERIAL_ADDER_OVF_EN adds the signed overflow output Ovf.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   A, B, Cin valid            in_ready   block can accept operands
//   A, B       WIDTH-bit operands         Cin        carry in
//   out_valid  Sum/Cout valid             out_ready  consumer accepts result
//   Sum        (A + B + Cin) mod 2^WIDTH  Cout       carry out of bit WIDTH-1
//   busy       operation in progress
//   Ovf        two's-complement overflow (only with CHUNKED_SERIAL_ADDER_OVF_EN)

module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]    LAST = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    count;

    logic [31:0]      base;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] result_next;

    // Current chunk is selected by shifting rather than indexed part-select so
    // the slice position stays a plain shift amount for any CHUNK/WIDTH pair.
    always_comb begin
        base        = CHUNK * 32'(count);
        a_shift     = op_a >> base;
        b_shift     = op_b >> base;
        a_chunk     = a_shift[CHUNK-1:0];
        b_chunk     = b_shift[CHUNK-1:0];
        chunk_sum   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        result_next = (result & ~(MASK << base))
                    | (WIDTH'(chunk_sum[CHUNK-1:0]) << base);
    end

`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
    logic ovf_next;
    // Carry into the MSB is recovered from the MSB sum bit; only meaningful
    // while the final chunk is being processed, which is the only time it is
    // captured.
    always_comb begin
        ovf_next = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            carry  <= 1'b0;
            count  <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_a  <= A;
                        op_b  <= B;
                        carry <= Cin;
                        count <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    result <= result_next;
                    carry  <= chunk_sum[CHUNK];
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        state <= S_DONE;
                        Sum   <= result_next;
                        Cout  <= chunk_sum[CHUNK];
`ifdef CHUNKED_SERIAL_ADDER_OVF_EN
                        Ovf   <= ovf_next;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign out_valid = (state == S_DONE);

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
Multi-cycle parametrised adder computing A + B + Cin over WIDTH bits, CHUNK bits per clock, with carry held in a register between chunks. It succeeds the single-bit full adder as the team's generic arithmetic block. Area scales with CHUNK, not WIDTH. It sits between producer and consumer stages behind valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand and result width in bits; must be an integer multiple of CHUNK
CHUNK, 8, bits added per clock cycle; CHUNK == WIDTH gives a single-cycle add
NCHUNK (localparam), WIDTH/CHUNK, number of chunk cycles per operation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands A, B, Cin are valid
in_ready  output  1  block can accept operands
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Cin  input  1  carry in
out_valid  output  1  Sum/Cout are valid
out_ready  input  1  consumer accepts result
Sum  output  WIDTH  (A + B + Cin) mod 2^WIDTH
Cout  output  1  carry out of bit WIDTH-1
busy  output  1  operation in progress (state RUN)

Behaviour:
- Reset: sampled on the rising clk edge while rst_n=0. Sets state IDLE, in_ready=1, out_valid=0, busy=0, Sum=0, Cout=0, chunk counter=0, carry register=0. Reset has priority over all other events. Reset in RUN or DONE aborts the operation and discards the partial result.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, latch A, B and Cin into internal operand registers, set carry=Cin and counter=0, and go to RUN. Otherwise stay in IDLE.
- RUN: in_ready=0, busy=1. Each cycle:
  - chunk k = counter; sum chunk = A[k*CHUNK +: CHUNK] + B[k*CHUNK +: CHUNK] + carry, computed with CHUNK+1 bit arithmetic.
  - Low CHUNK bits are written to the internal result at the same slice; bit CHUNK becomes the new carry.
  - Counter increments. On the edge that processes chunk NCHUNK-1, go to DONE and drive Sum and Cout from the completed result.
- DONE: out_valid=1; Sum and Cout held stable. Stay until out_ready=1 on an edge, then go to IDLE with out_valid=0 and in_ready=1.
- Latency: out_valid rises NCHUNK cycles after the accept edge. Throughput is one result per NCHUNK+2 cycles when in_valid and out_ready are held high.
- No overlap: in_valid is ignored outside IDLE. Changes on A, B or Cin after acceptance have no effect.
- Sum and Cout keep their last value after the output handshake until the next result is ready; they are only meaningful while out_valid=1.
- out_ready is ignored when out_valid=0.
- Boundary case NCHUNK=1: RUN lasts one cycle, latency 1.
- Wrap-around is modulo 2^WIDTH, with the carry reported on Cout.
- WIDTH % CHUNK != 0 must be rejected at elaboration (generate-time error).

Optional Feature:
CHUNKED_SERIAL_ADDER_OVF_EN:
- Defined: adds output port Ovf (1 bit), the two's-complement signed overflow flag. Ovf = carry into bit WIDTH-1 XOR Cout. It is computed in the final chunk cycle, valid with out_valid, held with Sum, and reset to 0.
- Not defined: no Ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
1. Defaults. A=0xFFFFFFFF, B=0x00000001, Cin=0 -> out_valid rises 4 cycles after accept; Sum=0x00000000, Cout=1.
2. A=0x12345678, B=0x11111111, Cin=1 -> Sum=0x2345678A, Cout=0; busy high for exactly 4 cycles.
3. Backpressure. Hold out_ready=0 for 5 cycles after out_valid rises, and drive in_valid=1 with new operands -> Sum/Cout stable, in_ready=0, new operands ignored. The first edge with out_ready=1 clears out_valid and raises in_ready.
4. Reset mid-operation. rst_n=0 on the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0, Sum=0, Cout=0. A fresh operation afterwards gives the correct result.
5. Back-to-back. Hold in_valid=1 and out_ready=1 with random operands -> one result every 6 cycles, every Sum/Cout matching the reference model. Repeat with CHUNK=32 (latency 1, period 3) and CHUNK=1 (latency 32).
6. With CHUNKED_SERIAL_ADDER_OVF_EN defined:
   - A=0x7FFFFFFF, B=0x00000001, Cin=0 -> Sum=0x80000000, Cout=0, Ovf=1.
   - A=0xFFFFFFFF, B=0x00000001 -> Ovf=0, Cout=1.
